fp16_stream_accum: RTL and testbench



---
 rtl/fp16_stream_accum.sv | 237 +++++++++++++++++++++++
 tb/tb_fp16_stream_accum.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_stream_accum.sv
`default_nettype none
// ============================================================================
//  Module      : fp16_stream_accum
//  Description : Packetised fp16 stream accumulator. Each accepted element
//                passes through a four-state align/add/normalise sequence
//                and one saturating, NaN-flagged fp16 sum is emitted per
//                packet.
//  Revision    : 1.0  initial release
// ============================================================================
module fp16_stream_accum (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_data,
    input  logic        s_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [15:0] m_data,
    output logic        m_ovf,
    output logic        m_nan
);

    localparam logic [2:0] c_ST_ACCEPT = 3'd0;
    localparam logic [2:0] c_ST_ALIGN  = 3'd1;
    localparam logic [2:0] c_ST_ADD    = 3'd2;
    localparam logic [2:0] c_ST_NORM   = 3'd3;
    localparam logic [2:0] c_ST_EMIT   = 3'd4;

    localparam logic [15:0] c_QNAN    = 16'h7E00;
    localparam logic [15:0] c_POS_MAX = 16'h7BFF;
    localparam logic [15:0] c_NEG_MAX = 16'hFBFF;

    // control / architectural state
    logic [2:0]  r_state;
    logic [15:0] r_acc;
    logic        r_ovf;
    logic        r_nan;
    logic [15:0] r_m_data;
    logic        r_m_ovf;
    logic        r_m_nan;

    // pipeline registers
    logic [15:0] r_in_data;
    logic        r_in_last;
    logic [13:0] r_mag_a;
    logic [13:0] r_mag_b;
    logic        r_sign_a;
    logic        r_sign_b;
    logic [4:0]  r_exp;
    logic [14:0] r_sum;
    logic        r_sum_sign;

    // align stage wires
    logic        w_a_zero;
    logic        w_b_zero;
    logic [4:0]  w_ea;
    logic [4:0]  w_eb;
    logic [13:0] w_ma;
    logic [13:0] w_mb;
    logic [4:0]  w_diff;
    logic [13:0] w_al_a;
    logic [13:0] w_al_b;
    logic [4:0]  w_al_exp;

    // add stage wires
    logic [14:0] w_sum;
    logic        w_sum_sign;

    // normalise stage wires
    logic [3:0]        w_lz;
    logic signed [6:0] w_norm_exp;
    logic [9:0]        w_norm_mant;
    logic [15:0]       w_acc_next;
    logic              w_sat;

    logic w_s_special;
    logic w_accept;
    logic w_emit_done;

    assign w_s_special = (s_data[14:10] == 5'd31);
    assign w_accept    = (r_state == c_ST_ACCEPT) && s_valid;
    assign w_emit_done = (r_state == c_ST_EMIT) && m_ready;

    assign s_ready = (r_state == c_ST_ACCEPT) && rst_n;
    assign m_valid = (r_state == c_ST_EMIT);
    assign m_data  = r_m_data;
    assign m_ovf   = r_m_ovf;
    assign m_nan   = r_m_nan;

    // Decode acc and the latched element, then align the smaller exponent to the larger
    always_comb begin
        // exp==0 (zero / flushed subnormal) and exp==31 (special) both contribute zero
        w_a_zero = (r_acc[14:10] == 5'd0) || (r_acc[14:10] == 5'd31);
        w_b_zero = (r_in_data[14:10] == 5'd0) || (r_in_data[14:10] == 5'd31);
        w_ea     = w_a_zero ? 5'd0 : r_acc[14:10];
        w_eb     = w_b_zero ? 5'd0 : r_in_data[14:10];
        w_ma     = w_a_zero ? 14'd0 : {1'b1, r_acc[9:0], 3'b000};
        w_mb     = w_b_zero ? 14'd0 : {1'b1, r_in_data[9:0], 3'b000};
        w_al_a   = w_ma;
        w_al_b   = w_mb;
        if (w_ea >= w_eb) begin
            w_diff   = w_ea - w_eb;
            w_al_exp = w_ea;
            w_al_b   = (w_diff >= 5'd14) ? 14'd0 : (w_mb >> w_diff);
        end else begin
            w_diff   = w_eb - w_ea;
            w_al_exp = w_eb;
            w_al_a   = (w_diff >= 5'd14) ? 14'd0 : (w_ma >> w_diff);
        end
    end

    // Signed-magnitude add of the aligned operands
    always_comb begin
        w_sum      = 15'd0;
        w_sum_sign = 1'b0;
        if (r_sign_a == r_sign_b) begin
            w_sum      = {1'b0, r_mag_a} + {1'b0, r_mag_b};
            w_sum_sign = r_sign_a;
        end else if (r_mag_a > r_mag_b) begin
            w_sum      = {1'b0, r_mag_a - r_mag_b};
            w_sum_sign = r_sign_a;
        end else if (r_mag_b > r_mag_a) begin
            w_sum      = {1'b0, r_mag_b - r_mag_a};
            w_sum_sign = r_sign_b;
        end
        // equal magnitudes, opposite signs: exact positive zero (defaults)
    end

    // Normalise, truncate guard bits, then flush/saturate into the next acc value
    always_comb begin
        w_lz = 4'd0;
        // ascending scan so the highest set bit decides the shift
        for (int i = 0; i < 14; i++) begin
            if (r_sum[i]) w_lz = 4'(13 - i);
        end
        if (r_sum[14]) begin
            w_norm_exp  = signed'({2'b00, r_exp}) + 7'sd1;
            w_norm_mant = r_sum[13:4];
        end else begin
            w_norm_exp  = signed'({2'b00, r_exp}) - signed'({3'b000, w_lz});
            w_norm_mant = 10'((r_sum[13:0] << w_lz) >> 3);
        end
        w_sat = 1'b0;
        if (r_sum == 15'd0) begin
            w_acc_next = 16'h0000;
        end else if (w_norm_exp < 7'sd1) begin
            w_acc_next = 16'h0000;
        end else if (w_norm_exp > 7'sd30) begin
            w_acc_next = r_sum_sign ? c_NEG_MAX : c_POS_MAX;
            w_sat      = 1'b1;
        end else begin
            w_acc_next = {r_sum_sign, w_norm_exp[4:0], w_norm_mant};
        end
    end

    // Sequencer, accumulator, sticky flags and registered packet outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_ST_ACCEPT;
            r_acc    <= 16'h0000;
            r_ovf    <= 1'b0;
            r_nan    <= 1'b0;
            r_m_data <= 16'h0000;
            r_m_ovf  <= 1'b0;
            r_m_nan  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_ACCEPT: begin
                    if (w_accept) begin
                        r_nan   <= r_nan | w_s_special;
                        r_state <= c_ST_ALIGN;
                    end
                end
                c_ST_ALIGN: r_state <= c_ST_ADD;
                c_ST_ADD:   r_state <= c_ST_NORM;
                c_ST_NORM: begin
                    r_acc <= w_acc_next;
                    r_ovf <= r_ovf | w_sat;
                    if (r_in_last) begin
                        r_m_data <= r_nan ? c_QNAN : w_acc_next;
                        r_m_ovf  <= r_ovf | w_sat;
                        r_m_nan  <= r_nan;
                        r_state  <= c_ST_EMIT;
                    end else begin
                        r_state <= c_ST_ACCEPT;
                    end
                end
                c_ST_EMIT: begin
                    if (w_emit_done) begin
                        r_acc    <= 16'h0000;
                        r_ovf    <= 1'b0;
                        r_nan    <= 1'b0;
                        r_m_data <= 16'h0000;
                        r_m_ovf  <= 1'b0;
                        r_m_nan  <= 1'b0;
                        r_state  <= c_ST_ACCEPT;
                    end
                end
                default: r_state <= c_ST_ACCEPT;
            endcase
        end
    end

    // Datapath pipeline: input latch, aligned operands, raw sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_data  <= 16'h0000;
            r_in_last  <= 1'b0;
            r_mag_a    <= 14'd0;
            r_mag_b    <= 14'd0;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_exp      <= 5'd0;
            r_sum      <= 15'd0;
            r_sum_sign <= 1'b0;
        end else begin
            if (w_accept) begin
                r_in_data <= s_data;
                r_in_last <= s_last;
            end
            if (r_state == c_ST_ALIGN) begin
                r_mag_a  <= w_al_a;
                r_mag_b  <= w_al_b;
                r_sign_a <= r_acc[15];
                r_sign_b <= r_in_data[15];
                r_exp    <= w_al_exp;
            end
            if (r_state == c_ST_ADD) begin
                r_sum      <= w_sum;
                r_sum_sign <= w_sum_sign;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp16_stream_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp16_stream_accum
//  Description : Directed self-checking bench for fp16_stream_accum with
//                hand-computed expected sums.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fp16_stream_accum;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        m_ovf;
    logic        m_nan;

    int n_total = 0;
    int n_bad   = 0;

    fp16_stream_accum u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_ovf   (m_ovf),
        .m_nan   (m_nan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Offer one element and return 1ns after the edge that accepts it
    task automatic send(input logic [15:0] d, input logic last);
        int cnt;
        cnt     = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!s_ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (!s_ready) chk("send_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Wait for a sum, check it, then complete the handshake
    task automatic get_sum(input string tag, input logic [15:0] ed, input logic eo, input logic en);
        int cnt;
        cnt = 0;
        while (!m_valid && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (!m_valid) chk({tag, "_timeout"}, 32'd0, 32'd1);
        chk({tag, "_data"}, 32'(m_data), 32'(ed));
        chk({tag, "_ovf"},  32'(m_ovf),  32'(eo));
        chk({tag, "_nan"},  32'(m_nan),  32'(en));
        @(negedge clk);
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        chk({tag, "_mvalid_drop"}, 32'(m_valid), 32'd0);
    endtask

    initial begin
        int cnt;
        int highs;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = 16'h0000;
        s_last  = 1'b0;
        m_ready = 1'b0;
        #2;
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data",  32'(m_data),  32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_s_ready", 32'(s_ready), 32'd1);

        // 1.0 + 2.0 with latency check
        @(negedge clk);
        send(16'h3C00, 1'b0);
        send(16'h4000, 1'b1);
        cnt = 0;
        while (!m_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("latency", 32'(cnt), 32'd4);
        get_sum("basic", 16'h4200, 1'b0, 1'b0);

        send(16'h3C00, 1'b0);
        send(16'hBC00, 1'b1);
        get_sum("cancel", 16'h0000, 1'b0, 1'b0);

        send(16'h6800, 1'b0);
        send(16'h3C00, 1'b1);
        get_sum("trunc", 16'h6800, 1'b0, 1'b0);

        send(16'hC000, 1'b0);
        send(16'h3C00, 1'b1);
        get_sum("negsum", 16'hBC00, 1'b0, 1'b0);

        send(16'h7BFF, 1'b0);
        send(16'h7BFF, 1'b1);
        get_sum("sat_pos", 16'h7BFF, 1'b1, 1'b0);

        send(16'h3C00, 1'b1);
        get_sum("after_sat", 16'h3C00, 1'b0, 1'b0);

        send(16'hFBFF, 1'b0);
        send(16'hFBFF, 1'b1);
        get_sum("sat_neg", 16'hFBFF, 1'b1, 1'b0);

        send(16'h3C00, 1'b0);
        send(16'h7C00, 1'b0);
        send(16'h0001, 1'b1);
        get_sum("special", 16'h7E00, 1'b0, 1'b1);

        // continuous s_valid: one accept per four cycles
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 16'h3C00;
        s_last  = 1'b0;
        highs   = 0;
        for (int i = 0; i < 16; i++) begin
            if (s_ready) highs++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        chk("throughput", 32'(highs), 32'd4);
        send(16'h3C00, 1'b1);
        get_sum("five", 16'h4500, 1'b0, 1'b0);

        // backpressure in EMIT with junk offered on the input
        send(16'h4400, 1'b1);
        cnt = 0;
        while (!m_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        s_valid = 1'b1;
        s_data  = 16'h5000;
        s_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_data",    32'(m_data),  32'h4400);
            chk("bp_s_ready", 32'(s_ready), 32'd0);
            chk("bp_m_valid", 32'(m_valid), 32'd1);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        get_sum("bp", 16'h4400, 1'b0, 1'b0);
        send(16'h4000, 1'b1);
        get_sum("post_bp", 16'h4000, 1'b0, 1'b0);

        // reset while in EMIT clears registered outputs immediately
        send(16'h3C00, 1'b1);
        cnt = 0;
        while (!m_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("emit_pre", 32'(m_data), 32'h3C00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("emit_rst_data",  32'(m_data),  32'h0);
        chk("emit_rst_valid", 32'(m_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // reset during ADD of the second element discards the partial packet
        @(negedge clk);
        send(16'h3C00, 1'b0);
        send(16'h4000, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("add_rst_s_ready", 32'(s_ready), 32'd0);
        chk("add_rst_m_valid", 32'(m_valid), 32'd0);
        chk("add_rst_m_ovf",   32'(m_ovf),   32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("add_rel_s_ready", 32'(s_ready), 32'd1);
        send(16'h4000, 1'b1);
        get_sum("post_rst", 16'h4000, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
